// File: rtl/data_memory_block.sv
// Block-granular backing memory answering the data cache's miss/write-back port.
// Each block read or write completes after a fixed number of busy cycles, then one DONE cycle.
module data_memory_block #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128,
    parameter int DEPTH       = 256,
    parameter int LATENCY     = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic [BLOCK_WIDTH-1:0] mem_write_data,
    output logic [BLOCK_WIDTH-1:0] mem_read_data,
    output logic                   mem_busywait
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_busy;
    logic                   w_req;
    logic                   w_access;
    logic [3:0]             r_counter;
    logic                   r_op_write;
    logic [IDX_W-1:0]       r_index;
    logic [BLOCK_WIDTH-1:0] r_wdata;
    logic [BLOCK_WIDTH-1:0] r_read_data;
    logic [BLOCK_WIDTH-1:0] r_mem [DEPTH];

    // Address bits above the index alias silently onto the same block.
    logic w_unused_addr;
    assign w_unused_addr = ^mem_address[ADDR_WIDTH-1:IDX_W];

    assign w_req    = mem_read | mem_write;
    assign w_access = (r_state == BUSY) && (r_counter == 4'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = w_req;
                if (w_req) w_next_state = BUSY;
            end
            BUSY: begin
                w_busy = 1'b1;
                if (r_counter == 4'd0) w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Busywait is held low throughout reset even if a request is already present.
    assign mem_busywait  = reset & w_busy;
    assign mem_read_data = r_read_data;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_counter   <= 4'd0;
            r_op_write  <= 1'b0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_op_write <= mem_write;
                r_index    <= mem_address[IDX_W-1:0];
                r_wdata    <= mem_write_data;
                r_counter  <= 4'(LATENCY - 1);
            end else if (r_state == BUSY && r_counter != 4'd0) begin
                r_counter <= r_counter - 4'd1;
            end
            if (w_access && !r_op_write) begin
                r_read_data <= r_mem[r_index];
            end
        end
    end

    // NOTE: the storage array has no reset; its contents must survive a reset of the control logic.
    always_ff @(posedge clock) begin
        if (w_access && r_op_write) begin
            r_mem[r_index] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_block.sv
// Self-checking bench for data_memory_block: a transaction-level model predicts busywait
// and read data every cycle, plus literal expectations for the directed scenarios.
module tb_data_memory_block;

    localparam int AW    = 28;
    localparam int BW    = 128;
    localparam int DEPTH = 256;
    localparam int LAT   = 5;

    localparam logic [BW-1:0] DATA1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [BW-1:0] VAL_A = 128'h11112222_33334444_55556666_77778888;
    localparam logic [BW-1:0] VAL_B = 128'hAAAABBBB_CCCCDDDD_EEEEFFFF_00001111;
    localparam logic [BW-1:0] VAL_C = 128'h0C0C0C0C_C0C0C0C0_12345678_9ABCDEF0;
    localparam logic [BW-1:0] VAL_D = 128'h0D0D0D0D_D0D0D0D0_FEDCBA98_76543210;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_address = '0;
    logic [BW-1:0] mem_write_data = '0;
    logic [BW-1:0] mem_read_data;
    logic          mem_busywait;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    data_memory_block #(
        .ADDR_WIDTH (AW),
        .BLOCK_WIDTH(BW),
        .DEPTH      (DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .mem_busywait  (mem_busywait)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: an accepted request occupies the port for LAT+1 busy cycles
    // (request cycle included) and its effect becomes visible in the following cycle.
    logic [BW-1:0] m_mem [DEPTH];
    logic [BW-1:0] m_rdata;
    logic [BW-1:0] m_data;
    logic          m_exp_bw;
    bit            m_active = 0;
    bit            m_wr;
    int            m_start;
    int            m_idx;
    int            cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            m_active = 0;
            m_rdata  = '0;
            m_exp_bw = 1'b0;
        end else if (m_active && cyc == m_start + LAT + 1) begin
            if (m_wr) m_mem[m_idx] = m_data;
            else      m_rdata = m_mem[m_idx];
            m_active = 0;
            m_exp_bw = 1'b0;
        end else if (m_active) begin
            m_exp_bw = 1'b1;
        end else begin
            m_exp_bw = mem_read | mem_write;
            if (m_exp_bw) begin
                m_active = 1;
                m_start  = cyc;
                m_wr     = mem_write;
                m_idx    = int'(mem_address % DEPTH);
                m_data   = mem_write_data;
            end
        end
        check("busywait", {{(BW-1){1'b0}}, mem_busywait}, {{(BW-1){1'b0}}, m_exp_bw});
        check("read_data", mem_read_data, m_rdata);
    end

    // Holds a request like the cache does; returns just after the first low-busywait sample.
    task automatic access(input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [BW-1:0] d, output int bw_cycles);
        bit done = 0;
        int n = 0;
        @(posedge clock); #1;
        mem_read = rd; mem_write = wr; mem_address = a; mem_write_data = d;
        bw_cycles = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
            if (mem_busywait) bw_cycles++;
            else done = 1;
        end
        check("access_timeout", {{(BW-1){1'b0}}, done}, {{(BW-1){1'b0}}, 1'b1});
    endtask

    task automatic go_idle();
        @(posedge clock); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        int n;
        bit done;

        // Reset: busywait forced low even with a request present.
        #2 mem_read = 1'b1;
        #1 check("rst_busywait", {{(BW-1){1'b0}}, mem_busywait}, '0);
        check("rst_rdata", mem_read_data, '0);
        mem_read = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // 1/2: write then read 0x10, six busy cycles each.
        access(0, 1, 28'h10, DATA1, n);
        check("t1_wr_busy_len", BW'(n), BW'(6));
        access(1, 0, 28'h10, '0, n);
        check("t1_rd_busy_len", BW'(n), BW'(6));
        check("t1_rdata", mem_read_data, DATA1);
        go_idle();

        // 3: eviction immediately followed by fetch of the same block.
        access(0, 1, 28'h3, VAL_A, n);
        access(1, 0, 28'h3, '0, n);
        check("t3_rd_busy_len", BW'(n), BW'(6));
        check("t3_rdata", mem_read_data, VAL_A);
        go_idle();

        // 4: single-cycle read pulse; input changes during BUSY are ignored.
        @(posedge clock); #1;
        mem_read = 1'b1; mem_address = 28'h10;
        @(posedge clock); #1;
        mem_read = 1'b0; mem_address = 28'h3;
        n = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (mem_busywait) n++;
            else done = 1;
        end
        check("t4_done_seen", {{(BW-1){1'b0}}, done}, {{(BW-1){1'b0}}, 1'b1});
        check("t4_busy_after_drop", BW'(n), BW'(5));
        check("t4_rdata", mem_read_data, DATA1);

        // 5: reset in the third BUSY cycle of a write abandons the write.
        access(0, 1, 28'h7, VAL_A, n);
        go_idle();
        @(posedge clock); #1;
        mem_write = 1'b1; mem_address = 28'h7; mem_write_data = VAL_B;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1 check("t5_busywait", {{(BW-1){1'b0}}, mem_busywait}, '0);
        check("t5_rdata", mem_read_data, '0);
        mem_write = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        access(1, 0, 28'h7, '0, n);
        check("t5_old_value", mem_read_data, VAL_A);
        go_idle();

        // 6: address wrap, then simultaneous read+write acts as a write.
        access(0, 1, 28'h105, VAL_C, n);
        access(1, 0, 28'h005, '0, n);
        check("t6_wrap", mem_read_data, VAL_C);
        access(1, 1, 28'h20, VAL_D, n);
        check("t6_rw_len", BW'(n), BW'(6));
        check("t6_rw_rdata_held", mem_read_data, VAL_C);
        access(1, 0, 28'h20, '0, n);
        check("t6_rw_written", mem_read_data, VAL_D);
        go_idle();

        repeat (4) @(posedge clock);
        #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
